rx_data_sampler: RTL
====================

Name: rx_data_sampler

Overview:
- UART RX front-end stage that sits directly upstream of the parity checker and the stop/start checkers.
- Contains the oversampling edge counter and the bit counter, three-point majority-vote sampling, and an LSB-first deserializer.
- Produces edge_cnt, bit_cnt, sampled_bit and P_DATA. The RX FSM and the parity check consume these outputs. sampled_bit is valid exactly when edge_cnt == (Prescale>>1)+2.

Parameters:
- DATA_W, 8, deserialized data width.
- PRESCALE_W, 6, width of the Prescale input.
- EDGE_W, 5, width of edge_cnt. Must hold Prescale-1 for the largest legal Prescale.

Ports:
- clk  input  1  system RX clock, oversampling rate.
- RST  input  1  synchronous, active-high reset.
- RX_IN  input  1  serial line, idle high.
- Prescale  input  PRESCALE_W  oversampling ratio. Legal values: 8, 16, 32.
- cnt_en  input  1  from RX FSM; runs the edge/bit counters.
- smp_en  input  1  from RX FSM; enables sampling.
- deser_en  input  1  from RX FSM; enables shifting of data bits.
- edge_cnt  output  EDGE_W  oversample edge index within the current bit.
- bit_cnt  output  4  bit index within the frame.
- sampled_bit  output  1  majority-voted bit value.
- smp_done  output  1  one-cycle pulse; sampled_bit has just been updated.
- P_DATA  output  DATA_W  deserialized byte.

Behaviour:
- Single clock domain. Every register updates on the rising edge of clk.
- RST is synchronous, active-high, and overrides all other inputs. Reset values: edge_cnt=0, bit_cnt=0, sampled_bit=1, smp_done=0, P_DATA=0, internal samples s0=s1=1.
- H = Prescale>>1.
- Counters:
  - cnt_en=0: edge_cnt and bit_cnt clear to 0 on the next edge.
  - cnt_en=1 and edge_cnt != Prescale-1: edge_cnt increments.
  - cnt_en=1 and edge_cnt == Prescale-1: edge_cnt becomes 0 and bit_cnt increments.
  - bit_cnt wraps mod 16 with no saturation. The FSM drops cnt_en before a wrap occurs.
- Sampling (active only when smp_en=1):
  - edge_cnt==H-1: s0 <= RX_IN.
  - edge_cnt==H: s1 <= RX_IN.
  - edge_cnt==H+1: sampled_bit <= majority(s0, s1, RX_IN), and smp_done is set for the next cycle.
  - Result: smp_done=1 exactly during the cycle where edge_cnt==H+2, and sampled_bit is stable from then until the next update.
  - smp_done is 0 in every other cycle.
  - smp_en=0: s0, s1 and sampled_bit hold their values; smp_done=0.
- Deserializer:
  - In the cycle where smp_done=1 and deser_en=1: P_DATA <= {sampled_bit, P_DATA[DATA_W-1:1]} (LSB first).
  - After 8 data bits, P_DATA[0] holds the first data bit received.
  - P_DATA holds its value at all other times, including when cnt_en is low. It is cleared only by RST.
- Latency: the line value at edges H-1, H and H+1 appears on sampled_bit 1 cycle after edge H+1. P_DATA updates 1 cycle after smp_done.
- Boundary conditions:
  - cnt_en falls mid-bit: counters clear next cycle. Any sample sequence in progress is abandoned, and no smp_done is produced for that bit.
  - cnt_en falls in the same cycle as a wrap: the clear wins (edge_cnt=0, bit_cnt=0).
  - RST during a sample window: no smp_done is produced, and sampled_bit returns to 1.
  - Prescale changes while cnt_en=1: behaviour undefined. The FSM changes Prescale only while idle.
  - Illegal Prescale (not 8, 16 or 32): behaviour undefined. The bench does not drive illegal values.
  - Glitch tolerance: a single-edge glitch inside the three-sample window is rejected by the vote.

Test Plan:
- Reset: assert RST for 2 cycles with RX_IN=0 and cnt_en=1. Required: edge_cnt=0, bit_cnt=0, sampled_bit=1, smp_done=0, P_DATA=0x00.
- Counter wrap: Prescale=8, hold cnt_en=1 for 20 cycles. Required: edge_cnt runs 0..7,0..7,0..3; bit_cnt steps 0→1 at cycle 8 and 1→2 at cycle 16.
- Majority vote: Prescale=16, smp_en=1, RX_IN=1 except 0 at edge 8 only. Required: at edge_cnt==10, smp_done=1 and sampled_bit=1. Repeat with 0 at edges 7 and 8. Required: sampled_bit=0.
- Byte capture: Prescale=8, drive 0xA5 LSB first with deser_en=1 for 8 bits. Required: 8 smp_done pulses, each at edge_cnt==6, and P_DATA=0xA5 after the last pulse.
- Abort: Prescale=32, drop cnt_en when edge_cnt=15. Required: edge_cnt=0 next cycle, no smp_done, sampled_bit and P_DATA unchanged.
- Prescale=32 sweep: one full bit with RX_IN=0. Required: smp_done at edge_cnt==18 with sampled_bit=0.

Source files
------------

// File: rtl/rx_data_sampler_if.sv
// Signal bundle between the RX FSM side and the data sampler.
// Control and serial line flow in; counters, vote and data flow out.
interface rx_data_sampler_if #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6,
  parameter int EDGE_W     = 5
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  cnt_en;
  logic                  smp_en;
  logic                  deser_en;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  sampled_bit;
  logic                  smp_done;
  logic [DATA_W-1:0]     P_DATA;

  modport master (
    output RX_IN, Prescale, cnt_en, smp_en, deser_en,
    input  edge_cnt, bit_cnt, sampled_bit, smp_done, P_DATA
  );

  modport slave (
    input  RX_IN, Prescale, cnt_en, smp_en, deser_en,
    output edge_cnt, bit_cnt, sampled_bit, smp_done, P_DATA
  );
endinterface

// File: rtl/rx_data_sampler.sv
// UART RX front end: oversample/bit counters, three-point
// majority vote and LSB-first deserializer.
module rx_data_sampler #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6,
  parameter int EDGE_W     = 5
) (
  input logic               clk,
  input logic               RST,
  rx_data_sampler_if.slave  bus
);
  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [3:0]        bit_q, bit_d;
  logic              s0_q, s0_d;
  logic              s1_q, s1_d;
  logic              smp_q, smp_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] pdata_q, pdata_d;

  logic [PRESCALE_W-1:0] edge_w;
  logic [PRESCALE_W-1:0] half;
  logic                  at_last;
  logic                  at_h0;
  logic                  at_h1;
  logic                  at_h2;
  logic                  smp_go;
  logic                  vote;

  assign edge_w  = PRESCALE_W'(edge_q);
  assign half    = bus.Prescale >> 1;
  assign at_last = edge_w == bus.Prescale - ONE;
  assign at_h0   = edge_w == half - ONE;
  assign at_h1   = edge_w == half;
  assign at_h2   = edge_w == half + ONE;

  // Sampling follows the counters: a dropped cnt_en
  // abandons the window so no late pulse leaks out.
  assign smp_go = bus.cnt_en & bus.smp_en;
  assign vote   = (s0_q & s1_q) | (s0_q & bus.RX_IN)
                | (s1_q & bus.RX_IN);

  always_comb begin
    edge_d  = edge_q;
    bit_d   = bit_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    smp_d   = smp_q;
    done_d  = 1'b0;
    pdata_d = pdata_q;

    if (!bus.cnt_en) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (at_last) begin
      edge_d = '0;
      bit_d  = bit_q + 4'd1;
    end else begin
      edge_d = edge_q + EDGE_W'(1);
    end

    if (smp_go) begin
      if (at_h0) s0_d = bus.RX_IN;
      if (at_h1) s1_d = bus.RX_IN;
      if (at_h2) begin
        smp_d  = vote;
        done_d = 1'b1;
      end
    end

    if (done_q && bus.deser_en)
      pdata_d = {smp_q, pdata_q[DATA_W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      edge_q  <= '0;
      bit_q   <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      smp_q   <= 1'b1;
      done_q  <= 1'b0;
      pdata_q <= '0;
    end else begin
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      smp_q   <= smp_d;
      done_q  <= done_d;
      pdata_q <= pdata_d;
    end
  end

  assign bus.edge_cnt    = edge_q;
  assign bus.bit_cnt     = bit_q;
  assign bus.sampled_bit = smp_q;
  assign bus.smp_done    = done_q;
  assign bus.P_DATA      = pdata_q;
endmodule
